conv_encoder: RTL

CONV_ENCODER -- requirements
Module: conv_encoder

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_encoder_if.sv | 13 +
 rtl/conv_enc_core.sv | 40 ++++
 rtl/conv_encoder.sv | 111 +++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and generator constants for the rate-1/2, K=3 convolutional encoder.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  // Tap vector is {b, s1, s0}; result is {g0, g1}.
  function automatic logic [1:0] encode(input logic b, input logic [K-2:0] s);
    logic [K-1:0] taps;
    taps = {b, s};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/conv_encoder_if.sv
// Handshake and symbol-output bundle between the bit source/symbol sink and the encoder.
interface conv_encoder_if;
  logic       start;
  logic       in;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] o;
  logic       enable;
  logic       busy;

  modport master (output start, in, in_valid, input in_ready, o, enable, busy);
  modport slave  (input start, in, in_valid, output in_ready, o, enable, busy);
endinterface

// File: rtl/conv_enc_core.sv
// Shift register and XOR network: one coded symbol per step, shift state cleared on frame start.
module conv_enc_core
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       step,
  input  logic       b,
  output logic [1:0] sym
);

  logic [K-2:0] s_q, s_d;
  logic [1:0]   sym_q, sym_d;

  // The symbol register is left alone on clear so o keeps its last value across frames.
  always_comb begin
    s_d   = s_q;
    sym_d = sym_q;
    if (clear) begin
      s_d = '0;
    end else if (step) begin
      sym_d = encode(b, s_q);
      s_d   = {b, s_q[K-2:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q   <= '0;
      sym_q <= '0;
    end else begin
      s_q   <= s_d;
      sym_q <= sym_d;
    end
  end

  assign sym = sym_q;

endmodule

// File: rtl/conv_encoder.sv
// Frame controller: paces symbols every DIV clocks, accepts FRAME_LEN data bits, then flushes two tail symbols.
module conv_encoder
  import conv_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int DIV       = 50
) (
  input logic           clk,
  input logic           reset,
  conv_encoder_if.slave bus
);

  localparam int BCW = $clog2(FRAME_LEN + 1);
  localparam int PCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PCW-1:0] PER_MAX  = PCW'(DIV - 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_LEN - 1);

  state_t         state_q, state_d;
  logic [PCW-1:0] per_q, per_d;
  logic [BCW-1:0] bit_q, bit_d;
  logic           tail_q, tail_d;
  logic           enable_q, enable_d;

  logic       tick;
  logic       xfer;
  logic       clear;
  logic       step;
  logic       enc_b;
  logic [1:0] sym;

  assign tick         = (per_q == PER_MAX);
  assign bus.in_ready = (state_q == DATA) && tick;
  assign xfer         = bus.in_ready && bus.in_valid;
  assign bus.busy     = (state_q != IDLE);
  assign bus.enable   = enable_q;
  assign bus.o        = sym;

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    bit_d   = bit_q;
    tail_d  = tail_q;
    clear   = 1'b0;
    step    = 1'b0;
    enc_b   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = DATA;
          clear   = 1'b1;
          per_d   = '0;
          bit_d   = '0;
          tail_d  = 1'b0;
        end
      end
      // On a tick without valid data the period counter parks at DIV-1 until in_valid rises.
      DATA: begin
        if (!tick) begin
          per_d = per_q + PCW'(1);
        end else if (xfer) begin
          step  = 1'b1;
          enc_b = bus.in;
          per_d = '0;
          bit_d = bit_q + BCW'(1);
          if (bit_q == LAST_BIT) state_d = TAIL;
        end
      end
      TAIL: begin
        if (!tick) begin
          per_d = per_q + PCW'(1);
        end else begin
          step   = 1'b1;
          per_d  = '0;
          tail_d = 1'b1;
          if (tail_q) begin
            state_d = IDLE;
            tail_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    enable_d = step;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      per_q    <= '0;
      bit_q    <= '0;
      tail_q   <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      bit_q    <= bit_d;
      tail_q   <= tail_d;
      enable_q <= enable_d;
    end
  end

  conv_enc_core u_core (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .step  (step),
    .b     (enc_b),
    .sym   (sym)
  );

endmodule
